// File: rtl/memshare_pipe_monitor_pkg.sv
// -----------------------------------------------------------------------------
// memshare_pipe_monitor_pkg
// Shared constants and types for the memShare() pipeline monitor.
//   MEMSHARE_DRC_NUM      : number of design-rule hit counters
//   MEMSHARE_DRC1/2/3     : counter index of each rule inside drc_cnt_o
//   phase_state_e         : phase FSM state (RUN / STALL)
// -----------------------------------------------------------------------------
package memshare_pipe_monitor_pkg;

    localparam int MEMSHARE_DRC_NUM = 3;

    localparam int MEMSHARE_DRC1 = 0;
    localparam int MEMSHARE_DRC2 = 1;
    localparam int MEMSHARE_DRC3 = 2;

    typedef enum logic [0:0] {
        PH_RUN   = 1'b0,
        PH_STALL = 1'b1
    } phase_state_e;

endpackage

// File: rtl/memshare_chan_track.sv
// -----------------------------------------------------------------------------
// memshare_chan_track
// Per-channel design-rule tracker: decodes a multi-sequence request, keeps the
// request history across one pipeline cycle and flags DRC1 / DRC2 hits.
// Ports:
//   sys_clk, rstn   : clock, asynchronous active-low reset
//   en_i            : run enable; low flushes the history
//   rqst_vld_i      : request present at SHIFT_GEN
//   seq_num_i       : allocation-sequence count of the request (0 acts as 1)
//   begin_i         : pipeline-cycle boundary from the phase FSM
//   drc1_o          : isolated multi-sequence request
//   drc2_o          : multi-sequence request completing a burst
//   block_o         : multi request issued PIPE_DEPTH-1 cycles ago
// -----------------------------------------------------------------------------
module memshare_chan_track
    import memshare_pipe_monitor_pkg::*;
#(
    parameter int PIPE_DEPTH = 4,
    parameter int SEQ_W      = 2,
    parameter int BURST_LEN  = 3
) (
    input  logic             sys_clk,
    input  logic             rstn,
    input  logic             en_i,
    input  logic             rqst_vld_i,
    input  logic [SEQ_W-1:0] seq_num_i,
    input  logic             begin_i,
    output logic             drc1_o,
    output logic             drc2_o,
    output logic             block_o
);

    logic                  multi;
    logic [PIPE_DEPTH-1:1] hist_q;
    logic [PIPE_DEPTH-1:1] hist_d;

    // Zero-extend before comparing so SEQ_W = 1 cannot truncate the constant.
    assign multi = en_i & rqst_vld_i & (32'(seq_num_i) >= 32'd2);

    // hist_q[k] holds the multi flag from k enabled cycles ago.
    always_comb begin
        hist_d = '0;
        if (en_i) begin
            hist_d = {hist_q[PIPE_DEPTH-2:1], multi};
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign drc2_o  = multi & (&hist_q[BURST_LEN-1:1]);
    assign drc1_o  = multi & ~drc2_o & ~begin_i;
    assign block_o = hist_q[PIPE_DEPTH-1];

endmodule

// File: rtl/memshare_pipe_monitor.sv
// -----------------------------------------------------------------------------
// memshare_pipe_monitor
// Multi-channel monitor of the SCU.memShare() pipeline. Tracks the pipeline
// phase, defers the cycle boundary while an older multi-sequence request is
// still in flight, flags stall overruns and counts design-rule hits.
// Ports:
//   sys_clk, rstn       : clock, asynchronous active-low reset
//   en_i                : run enable
//   rqst_vld_i          : per-channel request present
//   seq_num_i           : per-channel sequence count, channel c at [c*SEQ_W +: SEQ_W]
//   stat_clr_i          : clear hit counters and stall_err_o
//   phase_o             : current pipeline phase
//   pipeCycle_begin_o   : pipeline-cycle boundary (DRC3)
//   stall_o             : boundary deferred this cycle
//   drc1_o / drc2_o     : per-channel isolated / burst multi-sequence hits
//   drc_cnt_o           : saturating counters {DRC3, DRC2, DRC1}
//   stall_err_o         : sticky stall-overrun flag
// -----------------------------------------------------------------------------
module memshare_pipe_monitor
    import memshare_pipe_monitor_pkg::*;
#(
    parameter int CH_NUM     = 4,
    parameter int PIPE_DEPTH = 4,
    parameter int SEQ_W      = 2,
    parameter int BURST_LEN  = 3,
    parameter int STALL_MAX  = 4,
    parameter int CNT_W      = 16,
    parameter int PH_W       = $clog2(PIPE_DEPTH)
) (
    input  logic                          sys_clk,
    input  logic                          rstn,
    input  logic                          en_i,
    input  logic [CH_NUM-1:0]             rqst_vld_i,
    input  logic [CH_NUM*SEQ_W-1:0]       seq_num_i,
    input  logic                          stat_clr_i,
    output logic [PH_W-1:0]               phase_o,
    output logic                          pipeCycle_begin_o,
    output logic                          stall_o,
    output logic [CH_NUM-1:0]             drc1_o,
    output logic [CH_NUM-1:0]             drc2_o,
    output logic [MEMSHARE_DRC_NUM*CNT_W-1:0] drc_cnt_o,
    output logic                          stall_err_o
);

    localparam int              SC_W    = $clog2(STALL_MAX + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PIPE_DEPTH - 1);
    localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STALL_MAX);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic             hit);
        if (hit && (v != '1)) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    logic [CH_NUM-1:0]           blk;
    logic                        block;
    logic                        at_end;
    logic                        begin_w;
    logic                        stall_w;

    phase_state_e                state_q, state_d;
    logic [PH_W-1:0]             phase_q, phase_d;
    logic [SC_W-1:0]             stall_cnt_q, stall_cnt_d, stall_inc;
    logic                        err_q, err_d;
    logic [MEMSHARE_DRC_NUM-1:0] hit;
    logic [CNT_W-1:0]            cnt_q [MEMSHARE_DRC_NUM];
    logic [CNT_W-1:0]            cnt_d [MEMSHARE_DRC_NUM];

    // Per-channel request tracking
    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        memshare_chan_track #(
            .PIPE_DEPTH (PIPE_DEPTH),
            .SEQ_W      (SEQ_W),
            .BURST_LEN  (BURST_LEN)
        ) u_trk (
            .sys_clk    (sys_clk),
            .rstn       (rstn),
            .en_i       (en_i),
            .rqst_vld_i (rqst_vld_i[c]),
            .seq_num_i  (seq_num_i[c*SEQ_W +: SEQ_W]),
            .begin_i    (begin_w),
            .drc1_o     (drc1_o[c]),
            .drc2_o     (drc2_o[c]),
            .block_o    (blk[c])
        );
    end

    // Boundary decision: in both RUN at the last phase and STALL the FSM sits
    // at PH_LAST, so begin/stall reduce to the block test there. They are
    // complementary on block and therefore never both high.
    assign block   = |blk;
    assign at_end  = (phase_q == PH_LAST);
    assign begin_w = en_i & at_end & ~block;
    assign stall_w = en_i & at_end & block;

    // Phase FSM
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        if (!en_i) begin
            state_d = PH_RUN;
            phase_d = '0;
        end else begin
            case (state_q)
                PH_RUN: begin
                    if (!at_end) begin
                        phase_d = phase_q + PH_W'(1);
                    end else if (block) begin
                        state_d = PH_STALL;
                    end else begin
                        phase_d = '0;
                    end
                end
                PH_STALL: begin
                    if (!block) begin
                        state_d = PH_RUN;
                        phase_d = '0;
                    end
                end
                default: begin
                    state_d = PH_RUN;
                    phase_d = '0;
                end
            endcase
        end
    end

    // Stall-overrun tracking; stall_w is low whenever en_i is low, which
    // flushes the run length. The run length saturates at STALL_MAX.
    always_comb begin
        stall_inc   = (stall_cnt_q == SC_MAX) ? stall_cnt_q : stall_cnt_q + SC_W'(1);
        stall_cnt_d = stall_w ? stall_inc : '0;
        err_d       = stat_clr_i ? 1'b0 : (err_q | (stall_w & (stall_inc == SC_MAX)));
    end

    // Hit counters; clear takes priority over a same-cycle increment.
    always_comb begin
        hit                = '0;
        hit[MEMSHARE_DRC1] = |drc1_o;
        hit[MEMSHARE_DRC2] = |drc2_o;
        hit[MEMSHARE_DRC3] = begin_w;
        for (int k = 0; k < MEMSHARE_DRC_NUM; k++) begin
            cnt_d[k] = stat_clr_i ? '0 : sat_inc(cnt_q[k], hit[k]);
        end
    end

    // State registers
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= PH_RUN;
            phase_q     <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
            for (int k = 0; k < MEMSHARE_DRC_NUM; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
            for (int k = 0; k < MEMSHARE_DRC_NUM; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    for (genvar k = 0; k < MEMSHARE_DRC_NUM; k++) begin : g_cnt_out
        assign drc_cnt_o[k*CNT_W +: CNT_W] = cnt_q[k];
    end

    assign phase_o           = phase_q;
    assign pipeCycle_begin_o = begin_w;
    assign stall_o           = stall_w;
    assign stall_err_o       = err_q;

endmodule

// File: tb/tb_memshare_pipe_monitor.sv
module tb_memshare_pipe_monitor;

    logic        sys_clk = 1'b0;
    logic        rstn    = 1'b0;
    logic        en      = 1'b0;
    logic [3:0]  vld     = '0;
    logic [7:0]  seq     = '0;
    logic        clr     = 1'b0;
    logic [1:0]  phase;
    logic        beg, stl, err;
    logic [3:0]  d1, d2;
    logic [47:0] cnt;

    // Second instance with narrow counters for the saturation check
    logic        rstn2 = 1'b0;
    logic        en2   = 1'b0;
    logic [3:0]  vld2  = '0;
    logic [7:0]  seq2  = '0;
    logic        clr2  = 1'b0;
    logic [1:0]  phase2;
    logic        beg2, stl2, err2;
    logic [3:0]  d1_2, d2_2;
    logic [11:0] cnt2;

    int total = 0;
    int bad   = 0;

    always #5 sys_clk = ~sys_clk;

    memshare_pipe_monitor dut (
        .sys_clk(sys_clk), .rstn(rstn), .en_i(en), .rqst_vld_i(vld), .seq_num_i(seq),
        .stat_clr_i(clr), .phase_o(phase), .pipeCycle_begin_o(beg), .stall_o(stl),
        .drc1_o(d1), .drc2_o(d2), .drc_cnt_o(cnt), .stall_err_o(err)
    );

    memshare_pipe_monitor #(.CNT_W(4)) dut2 (
        .sys_clk(sys_clk), .rstn(rstn2), .en_i(en2), .rqst_vld_i(vld2), .seq_num_i(seq2),
        .stat_clr_i(clr2), .phase_o(phase2), .pipeCycle_begin_o(beg2), .stall_o(stl2),
        .drc1_o(d1_2), .drc2_o(d2_2), .drc_cnt_o(cnt2), .stall_err_o(err2)
    );

    typedef struct {
        int en, vld, seq, clr;
        int ph, b, s, d1, d2, c1, c2, c3, err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int en_v, input int vld_v, input int seq_v, input int clr_v,
                                input int ph, input int b, input int s, input int dd1, input int dd2,
                                input int c1, input int c2, input int c3, input int e);
        vec_t v;
        v.en = en_v; v.vld = vld_v; v.seq = seq_v; v.clr = clr_v;
        v.ph = ph; v.b = b; v.s = s; v.d1 = dd1; v.d2 = dd2;
        v.c1 = c1; v.c2 = c2; v.c3 = c3; v.err = e;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", nm, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // idle cycling: boundaries at phase 3, DRC3 counting
        for (int i = 0; i < 12; i++)
            vecs.push_back(mk(1, 0, 0, 0, i % 4, (i % 4 == 3) ? 1 : 0, 0, 0, 0, 0, 0, i / 4, 0));
        // single multi on ch0 -> DRC1, one stall cycle, delayed begin
        vecs.push_back(mk(1, 1, 'h02, 0, 0, 0, 0, 1, 0, 0, 0, 3, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 3, 0));
        vecs.push_back(mk(1, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 3, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3, 0, 1, 0, 0, 1, 0, 3, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3, 1, 0, 0, 0, 1, 0, 3, 0));
        // ch1 burst of three -> DRC1, DRC1, DRC2; three stall cycles
        vecs.push_back(mk(1, 2, 'h0C, 0, 0, 0, 0, 2, 0, 1, 0, 4, 0));
        vecs.push_back(mk(1, 2, 'h0C, 0, 1, 0, 0, 2, 0, 2, 0, 4, 0));
        vecs.push_back(mk(1, 2, 'h0C, 0, 2, 0, 0, 0, 2, 3, 0, 4, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3, 0, 1, 0, 0, 3, 1, 4, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3, 0, 1, 0, 0, 3, 1, 4, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3, 0, 1, 0, 0, 3, 1, 4, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3, 1, 0, 0, 0, 3, 1, 4, 0));
        // ch2 held -> long stall, stall_err_o after four stall cycles
        vecs.push_back(mk(1, 4, 'h20, 0, 0, 0, 0, 4, 0, 3, 1, 5, 0));
        vecs.push_back(mk(1, 4, 'h20, 0, 1, 0, 0, 4, 0, 4, 1, 5, 0));
        vecs.push_back(mk(1, 4, 'h20, 0, 2, 0, 0, 0, 4, 5, 1, 5, 0));
        vecs.push_back(mk(1, 4, 'h20, 0, 3, 0, 1, 0, 4, 5, 2, 5, 0));
        vecs.push_back(mk(1, 4, 'h20, 0, 3, 0, 1, 0, 4, 5, 3, 5, 0));
        vecs.push_back(mk(1, 4, 'h20, 0, 3, 0, 1, 0, 4, 5, 4, 5, 0));
        vecs.push_back(mk(1, 4, 'h20, 0, 3, 0, 1, 0, 4, 5, 5, 5, 0));
        vecs.push_back(mk(1, 4, 'h20, 0, 3, 0, 1, 0, 4, 5, 6, 5, 1));
        vecs.push_back(mk(1, 0, 0, 0, 3, 0, 1, 0, 0, 5, 7, 5, 1));
        vecs.push_back(mk(1, 0, 0, 0, 3, 0, 1, 0, 0, 5, 7, 5, 1));
        vecs.push_back(mk(1, 0, 0, 0, 3, 0, 1, 0, 0, 5, 7, 5, 1));
        // clear on a begin cycle: clear wins over the DRC3 increment
        vecs.push_back(mk(1, 0, 0, 1, 3, 1, 0, 0, 0, 5, 7, 5, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        // ch3 multi then en_i drop at phase 2 (history flushed, outputs gated)
        vecs.push_back(mk(1, 8, 'h80, 0, 1, 0, 0, 8, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 'h02, 0, 2, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 2, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 3, 1, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 1, 'h02, 0, 0, 0, 0, 1, 0, 1, 0, 1, 0));

        // reset state
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_phase", int'(phase), 0);
        chk("rst_begin", int'(beg), 0);
        chk("rst_stall", int'(stl), 0);
        chk("rst_cnt", int'(cnt[31:0]), 0);
        chk("rst_err", int'(err), 0);
        rstn = 1'b1;
        @(posedge sys_clk);
        #1;

        foreach (vecs[i]) begin
            en  = 1'(vecs[i].en);
            vld = 4'(vecs[i].vld);
            seq = 8'(vecs[i].seq);
            clr = 1'(vecs[i].clr);
            @(negedge sys_clk);
            chk($sformatf("v%0d_phase", i), int'(phase), vecs[i].ph);
            chk($sformatf("v%0d_begin", i), int'(beg), vecs[i].b);
            chk($sformatf("v%0d_stall", i), int'(stl), vecs[i].s);
            chk($sformatf("v%0d_drc1", i), int'(d1), vecs[i].d1);
            chk($sformatf("v%0d_drc2", i), int'(d2), vecs[i].d2);
            chk($sformatf("v%0d_cnt1", i), int'(cnt[15:0]), vecs[i].c1);
            chk($sformatf("v%0d_cnt2", i), int'(cnt[31:16]), vecs[i].c2);
            chk($sformatf("v%0d_cnt3", i), int'(cnt[47:32]), vecs[i].c3);
            chk($sformatf("v%0d_err", i), int'(err), vecs[i].err);
            @(posedge sys_clk);
            #1;
        end

        // ch0 multi from the last vector produces a stall at phase 3; reset there
        en = 1'b1; vld = '0; seq = '0; clr = 1'b0;
        @(negedge sys_clk);
        chk("ms_phase1", int'(phase), 1);
        @(posedge sys_clk); #1;
        @(negedge sys_clk);
        chk("ms_phase2", int'(phase), 2);
        @(posedge sys_clk); #1;
        @(negedge sys_clk);
        chk("ms_stall", int'(stl), 1);
        chk("ms_phase3", int'(phase), 3);
        #2 rstn = 1'b0;
        #1;
        chk("async_phase", int'(phase), 0);
        chk("async_stall", int'(stl), 0);
        chk("async_begin", int'(beg), 0);
        chk("async_cnt", int'(cnt[31:0]) | int'(cnt[47:32]), 0);
        chk("async_err", int'(err), 0);
        chk("async_drc", int'({d1, d2}), 0);
        @(posedge sys_clk); #1;
        @(negedge sys_clk);
        rstn = 1'b1;

        // saturation of a 4-bit DRC3 counter over 81 idle cycles
        @(negedge sys_clk);
        rstn2 = 1'b1;
        @(posedge sys_clk); #1;
        en2 = 1'b1;
        for (int n = 0; n <= 80; n++) begin
            @(negedge sys_clk);
            chk($sformatf("sat_cnt3_n%0d", n), int'(cnt2[11:8]), (n / 4 < 15) ? n / 4 : 15);
            @(posedge sys_clk); #1;
        end
        chk("sat_cnt1", int'(cnt2[7:0]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
